// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-domain consumer for the fifo2 async FIFO.
// Pops into a 2-entry skid buffer and checks words against an incrementing sequence.
module fifo_rd_drain #(
    parameter int              DSIZE    = 8,
    parameter int              CNTW     = 16,
    parameter logic [DSIZE-1:0] EXP_INIT = DSIZE'(1)
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DSIZE-1:0] fifo_rdata,
    input  logic             fifo_rempty,
    output logic             fifo_rinc,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNTW-1:0]  word_cnt,
    output logic [CNTW-1:0]  err_cnt,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DSIZE-1:0] buf0;
    logic [DSIZE-1:0] buf1;
    logic [1:0]       occ;
    logic [DSIZE-1:0] exp_d;
    logic             push;
    logic             pull;

    assign m_valid   = (occ != 2'd0);
    assign m_data    = buf0;
    assign pull      = m_valid & m_ready;
    // A full buffer may still accept a word when its head leaves this cycle.
    assign push      = (state == RUN) & ~fifo_rempty
                     & ((occ < 2'd2) | pull);
    assign fifo_rinc = push;
    assign busy      = (state != IDLE);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (en) begin
                    state_nxt = RUN;
                end else if (occ == 2'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            buf0 <= '0;
            buf1 <= '0;
            occ  <= 2'd0;
        end else begin
            case ({push, pull})
                2'b10: begin
                    if (occ == 2'd0) begin
                        buf0 <= fifo_rdata;
                    end else begin
                        buf1 <= fifo_rdata;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= fifo_rdata;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Expected value follows the last popped word so the checker resyncs.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            word_cnt <= '0;
            err_cnt  <= '0;
            err      <= 1'b0;
            exp_d    <= EXP_INIT;
        end else if (clr) begin
            word_cnt <= '0;
            err_cnt  <= '0;
            err      <= 1'b0;
            exp_d    <= EXP_INIT;
        end else if (push) begin
            word_cnt <= word_cnt + CNTW'(1);
            exp_d    <= fifo_rdata + DSIZE'(1);
            if (fifo_rdata != exp_d) begin
                err <= 1'b1;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + CNTW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: queue-based FIFO model, output scoreboard
// and a sequence-rule model for the checker counters.
module tb_fifo_rd_drain;

    localparam logic [7:0] EXP0 = 8'd250;

    logic        rclk;
    logic        rrst_n;
    logic        en;
    logic        clr;
    logic [7:0]  fifo_rdata;
    logic        fifo_rempty;
    logic        fifo_rinc;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] word_cnt;
    logic [15:0] err_cnt;
    logic        err;
    logic        busy;

    logic [7:0]  fq[$];
    logic [7:0]  exp_q[$];
    int          pops;
    int          n_chk;
    int          n_pass;

    fifo_rd_drain #(
        .DSIZE(8),
        .CNTW(16),
        .EXP_INIT(EXP0)
    ) dut (
        .rclk(rclk),
        .rrst_n(rrst_n),
        .en(en),
        .clr(clr),
        .fifo_rdata(fifo_rdata),
        .fifo_rempty(fifo_rempty),
        .fifo_rinc(fifo_rinc),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .word_cnt(word_cnt),
        .err_cnt(err_cnt),
        .err(err),
        .busy(busy)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endfunction

    function automatic void refresh();
        fifo_rempty = (fq.size() == 0);
        fifo_rdata  = fifo_rempty ? 8'h00 : fq[0];
    endfunction

    task automatic push(logic [7:0] d);
        fq.push_back(d);
        exp_q.push_back(d);
        refresh();
    endtask

    task automatic tick();
        @(posedge rclk);
        #2;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic drain(string nm);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 3000) begin
            tick();
            c++;
        end
        chk(nm, exp_q.size(), 0);
        tick();
    endtask

    // FIFO model: a pop seen before the edge removes the head just after it.
    initial begin
        bit pend;
        forever begin
            @(negedge rclk);
            pend = rrst_n && fifo_rinc;
            @(posedge rclk);
            #1;
            if (pend && fq.size() != 0) begin
                void'(fq.pop_front());
                pops++;
                refresh();
            end
        end
    end

    always @(negedge rclk) begin
        if (rrst_n) begin
            if (fifo_rinc) begin
                chk("rinc_while_empty", fifo_rempty, 0);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL extra_word: got %0h expected none", m_data);
                end else begin
                    chk("m_data", m_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int gap;
        int p0;
        int p1;
        int k;
        int ec;
        bit seen;
        logic [7:0] v;
        logic [7:0] e;
        logic [7:0] sent[$];

        n_chk   = 0;
        n_pass  = 0;
        pops    = 0;
        rrst_n  = 1'b0;
        en      = 1'b1;
        clr     = 1'b0;
        m_ready = 1'b1;
        refresh();

        // T1: reset held with data present and en=1
        for (int i = 0; i < 120; i++) begin
            push(8'(EXP0 + 8'(i)));
        end
        repeat (4) tick();
        chk("t1_rinc", fifo_rinc, 0);
        chk("t1_valid", m_valid, 0);
        chk("t1_mdata", m_data, 0);
        chk("t1_wcnt", word_cnt, 0);
        chk("t1_ecnt", err_cnt, 0);
        chk("t1_err", err, 0);
        chk("t1_busy", busy, 0);
        chk("t1_pops", pops, 0);

        // T2: full-rate stream of 120 words
        rrst_n = 1'b1;
        c = 0;
        gap = 0;
        seen = 0;
        while (exp_q.size() != 0 && c < 1000) begin
            tick();
            c++;
            if (m_valid) begin
                seen = 1;
            end else if (seen && exp_q.size() != 0) begin
                gap++;
            end
        end
        chk("t2_drain", exp_q.size(), 0);
        chk("t2_gap", gap, 0);
        chk("t2_wcnt", word_cnt, 120);
        chk("t2_err", err, 0);
        chk("t2_ecnt", err_cnt, 0);
        chk("t2_rinc_idle", fifo_rinc, 0);

        // T3: backpressure with 10 queued words
        m_ready = 1'b0;
        p0 = pops;
        for (int i = 120; i < 130; i++) begin
            push(8'(EXP0 + 8'(i)));
        end
        repeat (6) tick();
        chk("t3_pops", pops - p0, 2);
        chk("t3_rinc", fifo_rinc, 0);
        chk("t3_valid", m_valid, 1);
        chk("t3_head", m_data, 8'(EXP0 + 8'd120));
        repeat (3) tick();
        chk("t3_hold", m_data, 8'(EXP0 + 8'd120));
        m_ready = 1'b1;
        drain("t3_drain");
        chk("t3_wcnt", word_cnt, 130);
        chk("t3_err", err, 0);

        // T4: one corrupt jump gives one error
        clr_pulse();
        e = EXP0;
        push(e);
        repeat (3) tick();
        chk("t4_w1", err_cnt, 0);
        push(8'(e + 8'd1));
        repeat (3) tick();
        chk("t4_w2", err_cnt, 0);
        push(8'(e + 8'd4));
        repeat (3) tick();
        chk("t4_w3_ecnt", err_cnt, 1);
        chk("t4_w3_err", err, 1);
        push(8'(e + 8'd5));
        repeat (3) tick();
        chk("t4_w4_ecnt", err_cnt, 1);
        chk("t4_wcnt", word_cnt, 4);
        drain("t4_drain");
        clr_pulse();
        chk("t4_clr_err", err, 0);
        chk("t4_clr_ecnt", err_cnt, 0);
        chk("t4_clr_wcnt", word_cnt, 0);

        // clr wins over a pop in the same cycle
        push(8'd7);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        push(EXP0);
        repeat (3) tick();
        chk("clrpop_wcnt", word_cnt, 1);
        chk("clrpop_err", err, 0);
        drain("clrpop_drain");

        // T5: wrap 250..4 with en dropped mid-stream
        clr_pulse();
        p0 = pops;
        for (int i = 0; i < 11; i++) begin
            push(8'(EXP0 + 8'(i)));
        end
        c = 0;
        while (pops - p0 < 3 && c < 50) begin
            tick();
            c++;
        end
        chk("t5_three", (pops - p0 >= 3), 1);
        en = 1'b0;
        m_ready = 1'b0;
        tick();
        p1 = pops;
        repeat (4) tick();
        chk("t5_nopop", pops, p1);
        chk("t5_busy_stop", busy, 1);
        chk("t5_valid_held", m_valid, 1);
        m_ready = 1'b1;
        c = 0;
        while (m_valid && c < 10) begin
            tick();
            c++;
        end
        chk("t5_empty", m_valid, 0);
        chk("t5_busy_lag", busy, 1);
        tick();
        chk("t5_busy_idle", busy, 0);
        en = 1'b1;
        drain("t5_drain");
        chk("t5_err", err, 0);
        chk("t5_ecnt", err_cnt, 0);
        chk("t5_wcnt", word_cnt, 11);

        // T6: async reset with two buffered words
        clr_pulse();
        m_ready = 1'b0;
        p0 = pops;
        push(EXP0);
        push(8'(EXP0 + 8'd1));
        repeat (5) tick();
        chk("t6_pops", pops - p0, 2);
        chk("t6_valid_pre", m_valid, 1);
        chk("t6_wcnt_pre", word_cnt, 2);
        #1;
        rrst_n = 1'b0;
        #1;
        chk("t6_valid", m_valid, 0);
        chk("t6_wcnt", word_cnt, 0);
        chk("t6_ecnt", err_cnt, 0);
        chk("t6_busy", busy, 0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        m_ready = 1'b1;
        tick();
        rrst_n = 1'b1;
        push(EXP0);
        push(8'(EXP0 + 8'd1));
        drain("t6_drain");
        chk("t6_post_err", err, 0);
        chk("t6_post_wcnt", word_cnt, 2);

        // T7: random traffic, random stalls and en gaps
        clr_pulse();
        v = EXP0;
        for (int i = 0; i < 200;) begin
            m_ready = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 9) != 0);
            k = $urandom_range(0, 2);
            for (int j = 0; j < k && i < 200; j++) begin
                if ($urandom_range(0, 7) == 0) begin
                    v = 8'($urandom);
                end
                push(v);
                sent.push_back(v);
                v = v + 8'd1;
                i++;
            end
            tick();
        end
        en = 1'b1;
        m_ready = 1'b1;
        drain("t7_drain");
        e = EXP0;
        ec = 0;
        foreach (sent[j]) begin
            if (sent[j] != e) begin
                ec++;
            end
            e = sent[j] + 8'd1;
        end
        chk("t7_wcnt", word_cnt, sent.size());
        chk("t7_ecnt", err_cnt, ec);
        chk("t7_err", err, (ec != 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
